count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 64 ++++++
 tb/tb_count_monitor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: debounces an asynchronous ripple-counter value, tracks wrap-arounds
// into an extended count and flags threshold matches.
module count_monitor #(
    parameter int STABLE_N = 2,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              en,
    input  logic              clr,
    input  logic [3:0]        thresh,
    output logic [3:0]        cnt_val,
    output logic              upd,
    output logic              wrap_pulse,
    output logic              thresh_hit,
    output logic [WRAP_W+3:0] ext_count,
    output logic              ovf,
    output logic              valid
);
    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
    localparam logic [2:0] STAB = 3'(STABLE_N);
    state_t state, state_nx;
    logic [3:0] s1, s2, s2_d;
    logic [2:0] stab_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic acc, wrap, hit;
    // stab_cnt lags s2 by a cycle, so s2 == s2_d blocks a value that has only just arrived
    always_comb begin
        acc = state != IDLE && stab_cnt == STAB && s2 == s2_d && (s2 != cnt_val || state == SEED);
        wrap = acc && state == RUN && s2 < cnt_val;
        hit = acc && state == RUN && s2 == thresh;
        state_nx = !en ? IDLE : state == IDLE ? SEED : (state == SEED && acc) ? RUN : state;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s2_d <= '0;
            stab_cnt <= '0;
            cnt_val <= '0;
            wrap_cnt <= '0;
            ovf <= 1'b0;
            upd <= 1'b0;
            wrap_pulse <= 1'b0;
            thresh_hit <= 1'b0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            s2_d <= s2;
            stab_cnt <= s2 != s2_d ? 3'd0 : stab_cnt == STAB ? stab_cnt : stab_cnt + 3'd1;
            cnt_val <= acc ? s2 : cnt_val;
            upd <= acc;
            wrap_pulse <= wrap;
            thresh_hit <= hit;
            wrap_cnt <= clr ? '0 : wrap ? wrap_cnt + 1'b1 : wrap_cnt;
            ovf <= clr ? 1'b0 : (wrap && &wrap_cnt) ? 1'b1 : ovf;
        end
    assign ext_count = {wrap_cnt, cnt_val};
    assign valid = state == RUN;
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: table-driven and scoreboard bench for count_monitor.
module tb_count_monitor;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic [3:0] cnt_in = 4'hF, thresh = 4'h5;
    logic [3:0] cnt_val;
    logic upd, wrap_pulse, thresh_hit, ovf, valid;
    logic [11:0] ext_count;
    int checks = 0, errors = 0;
    logic [7:0] m_wrap = 8'h00;
    logic m_ovf = 1'b0;

    typedef struct {logic [3:0] v; logic w; logic h; logic [11:0] ext; logic o;} exp_t;
    typedef struct {logic [3:0] cin; logic acc; logic w; logic h;} vec_t;
    exp_t q[$];
    vec_t tbl[13];

    count_monitor #(.STABLE_N(2), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en), .clr(clr), .thresh(thresh),
        .cnt_val(cnt_val), .upd(upd), .wrap_pulse(wrap_pulse), .thresh_hit(thresh_hit),
        .ext_count(ext_count), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] v, input logic w, input logic h);
        if (clr) begin
            m_wrap = 8'h00;
            m_ovf = 1'b0;
        end else if (w) begin
            if (m_wrap == 8'hFF) m_ovf = 1'b1;
            m_wrap = m_wrap + 8'h01;
        end
        q.push_back('{v, w, h, {m_wrap, v}, m_ovf});
    endtask

    task automatic run_edges(input int n, input int lat);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (upd) begin
                if (q.size() == 0) chk("unexpected_upd", 32'(upd), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("cnt_val", 32'(cnt_val), 32'(e.v));
                    chk("wrap_pulse", 32'(wrap_pulse), 32'(e.w));
                    chk("thresh_hit", 32'(thresh_hit), 32'(e.h));
                    chk("ext_count", 32'(ext_count), 32'(e.ext));
                    chk("ovf", 32'(ovf), 32'(e.o));
                    if (lat != 0) chk("latency", k, lat);
                end
            end else if (wrap_pulse || thresh_hit)
                chk("stray_pulse", 32'({wrap_pulse, thresh_hit}), 32'd0);
        end
        if (q.size() != 0) begin
            chk("missing_upd", q.size(), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        tbl = '{'{4'h0, 1'b1, 1'b1, 1'b0}, '{4'h3, 1'b1, 1'b0, 1'b0}, '{4'h3, 1'b0, 1'b0, 1'b0},
                '{4'h4, 1'b1, 1'b0, 1'b0}, '{4'h5, 1'b1, 1'b0, 1'b1}, '{4'h2, 1'b1, 1'b1, 1'b0},
                '{4'h5, 1'b1, 1'b0, 1'b1}, '{4'h1, 1'b1, 1'b1, 1'b0}, '{4'h1, 1'b0, 1'b0, 1'b0},
                '{4'hF, 1'b1, 1'b0, 1'b0}, '{4'h5, 1'b1, 1'b1, 1'b1}, '{4'h3, 1'b1, 1'b1, 1'b0},
                '{4'h3, 1'b0, 1'b0, 1'b0}};
        #2 rst = 1'b0;
        #1 chk("reset_state", 32'({cnt_val, upd, wrap_pulse, thresh_hit, ext_count, ovf, valid}), 32'd0);
        #20 rst = 1'b1;
        @(posedge clk);
        #1 en = 1'b1;
        push(4'hF, 1'b0, 1'b0);
        run_edges(14, 0);
        chk("seed_valid", 32'(valid), 32'd1);
        foreach (tbl[i]) begin
            cnt_in = tbl[i].cin;
            if (tbl[i].acc) push(tbl[i].cin, tbl[i].w, tbl[i].h);
            run_edges(8, tbl[i].acc ? 6 : 0);
        end
        cnt_in = 4'h7;
        run_edges(2, 0);
        cnt_in = 4'h3;
        run_edges(8, 0);
        cnt_in = 4'h4;
        push(4'h4, 1'b0, 1'b0);
        run_edges(8, 6);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        m_wrap = 8'h00;
        m_ovf = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cnt_in = 4'h8;
            push(4'h8, 1'b0, 1'b0);
            run_edges(8, 6);
            cnt_in = 4'h0;
            push(4'h0, 1'b1, 1'b0);
            run_edges(8, 6);
        end
        chk("wrap_cnt_rolled", 32'(ext_count[11:4]), 32'd0);
        chk("ovf_set", 32'(ovf), 32'd1);
        cnt_in = 4'h9;
        push(4'h9, 1'b0, 1'b0);
        run_edges(8, 6);
        cnt_in = 4'h2;
        run_edges(5, 0);
        clr = 1'b1;
        push(4'h2, 1'b1, 1'b0);
        run_edges(1, 1);
        clr = 1'b0;
        run_edges(2, 0);
        chk("ovf_cleared", 32'(ovf), 32'd0);
        cnt_in = 4'h4;
        push(4'h4, 1'b0, 1'b0);
        run_edges(8, 6);
        cnt_in = 4'h5;
        push(4'h5, 1'b0, 1'b1);
        run_edges(8, 6);
        en = 1'b0;
        cnt_in = 4'h1;
        run_edges(10, 0);
        chk("idle_hold", 32'(cnt_val), 32'h5);
        chk("idle_valid", 32'(valid), 32'd0);
        en = 1'b1;
        push(4'h1, 1'b0, 1'b0);
        run_edges(10, 0);
        chk("reseed_valid", 32'(valid), 32'd1);
        cnt_in = 4'h7;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("mid_reset", 32'({cnt_val, upd, wrap_pulse, thresh_hit, ext_count, ovf, valid}), 32'd0);
        #2 rst = 1'b1;
        m_wrap = 8'h00;
        m_ovf = 1'b0;
        push(4'h7, 1'b0, 1'b0);
        run_edges(14, 0);
        chk("restart_valid", 32'(valid), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
